// File: rtl/cpu_core_pkg.sv
// Shared types and encodings for the multicycle cpu_core: FSM states,
// opcode/op field values, shifter encodings and the B-operand shifter.
package cpu_core_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    function automatic logic [15:0] shift16(input logic [15:0] b, input logic [1:0] sh);
        case (sh)
            SH_NONE: shift16 = b;
            SH_LSL:  shift16 = {b[14:0], 1'b0};
            SH_LSR:  shift16 = {1'b0, b[15:1]};
            SH_ASR:  shift16 = {b[15], b[15:1]};
            default: shift16 = b;
        endcase
    endfunction

endpackage

// File: rtl/cpu_core_datapath.sv
// Datapath for cpu_core: eight-entry register file, A/B/C operand/result
// registers, B-operand shifter, ALU and the CMP status register.
module regfile (
    input  logic        clk,
    input  logic        write,
    input  logic [2:0]  writenum,
    input  logic [15:0] data_in,
    input  logic [2:0]  readnum,
    output logic [15:0] data_out
);
    logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;

    // NOTE: the register file has no reset; its contents must survive a reset.
    always_ff @(posedge clk) begin
        if (write) begin
            case (writenum)
                3'd0: R0 <= data_in;
                3'd1: R1 <= data_in;
                3'd2: R2 <= data_in;
                3'd3: R3 <= data_in;
                3'd4: R4 <= data_in;
                3'd5: R5 <= data_in;
                3'd6: R6 <= data_in;
                default: R7 <= data_in;
            endcase
        end
    end

    always_comb begin
        data_out = R0;
        case (readnum)
            3'd1: data_out = R1;
            3'd2: data_out = R2;
            3'd3: data_out = R3;
            3'd4: data_out = R4;
            3'd5: data_out = R5;
            3'd6: data_out = R6;
            3'd7: data_out = R7;
            default: data_out = R0;
        endcase
    end
endmodule

module datapath
    import cpu_core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  readnum,
    input  logic [2:0]  writenum,
    input  logic        write,
    input  logic        vsel,
    input  logic [15:0] sximm8,
    input  logic        loada,
    input  logic        loadb,
    input  logic        asel,
    input  logic [1:0]  shift,
    input  logic [1:0]  aluop,
    input  logic        loadc,
    input  logic        loads,
    output logic [15:0] out,
    output logic        n,
    output logic        v,
    output logic        z
);
    logic [15:0] a, b, rdata, wdata, ain, bsh, alu_out;
    logic        ovf;

    assign wdata = vsel ? sximm8 : out;

    regfile REGFILE (
        .clk      (clk),
        .write    (write),
        .writenum (writenum),
        .data_in  (wdata),
        .readnum  (readnum),
        .data_out (rdata)
    );

    assign ain = asel ? 16'd0 : a;
    assign bsh = shift16(b, shift);

    always_comb begin
        alu_out = ain + bsh;
        case (aluop)
            OP_ADD:  alu_out = ain + bsh;
            OP_CMP:  alu_out = ain - bsh;
            OP_AND:  alu_out = ain & bsh;
            OP_MVN:  alu_out = ~bsh;
            default: alu_out = ain + bsh;
        endcase
    end

    // Subtraction overflow: operand signs differ and the result sign left A's.
    assign ovf = (ain[15] != bsh[15]) && (alu_out[15] != ain[15]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which lets a write target its own source.
    always_ff @(posedge clk) begin
        if (reset) begin
            a   <= '0;
            b   <= '0;
            out <= '0;
            n   <= 1'b0;
            v   <= 1'b0;
            z   <= 1'b0;
        end else begin
            if (loada) a <= rdata;
            if (loadb) b <= rdata;
            if (loadc) out <= alu_out;
            if (loads) begin
                n <= alu_out[15];
                v <= ovf;
                z <= (alu_out == 16'd0);
            end
        end
    end
endmodule

// File: rtl/cpu_core.sv
// Top of the multicycle CPU: instruction register, field decoder and the
// Moore FSM that sequences the shared datapath one instruction at a time.
module cpu_core
    import cpu_core_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        N,
    output logic        V,
    output logic        Z,
    output logic        w
);
    state_t      state, state_next;
    logic [15:0] ir, sximm8;
    logic [2:0]  opcode, rn, rd, rm;
    logic [1:0]  op, sh, aluop;
    logic        is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;
    logic [2:0]  readnum, writenum;
    logic        write, vsel, loada, loadb, asel, loadc, loads;

    always_ff @(posedge clk) begin
        if (load) ir <= in;
    end

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};

    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_alu     = (opcode == OPC_ALU);
    assign is_cmp     = is_alu && (op == OP_CMP);
    assign is_mvn     = is_alu && (op == OP_MVN);
    // MOV-reg runs through the adder as 0 + sh(Rm).
    assign aluop      = is_mov_reg ? OP_ADD : op;

    always_ff @(posedge clk) begin
        if (reset) state <= S_WAIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT:      if (s) state_next = S_DECODE;
            S_DECODE: begin
                if (is_mov_imm)                state_next = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn) state_next = S_GET_B;
                else if (is_alu)               state_next = S_GET_A;
                else                           state_next = S_WAIT;
            end
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_ALU;
            S_ALU:       state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: state_next = S_WAIT;
            S_WRITE_REG: state_next = S_WAIT;
            default:     state_next = S_WAIT;
        endcase
    end

    // Writes are suppressed on a reset edge so an aborted instruction leaves no trace.
    always_comb begin
        w        = 1'b0;
        readnum  = rn;
        writenum = rd;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        case (state)
            S_WAIT:      w = 1'b1;
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = ~reset;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                asel  = is_mov_reg;
                loads = is_cmp;
                loadc = ~is_cmp;
            end
            S_WRITE_REG: begin
                writenum = rd;
                write    = ~reset;
            end
            default: w = 1'b0;
        endcase
    end

    datapath DP (
        .clk      (clk),
        .reset    (reset),
        .readnum  (readnum),
        .writenum (writenum),
        .write    (write),
        .vsel     (vsel),
        .sximm8   (sximm8),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .shift    (sh),
        .aluop    (aluop),
        .loadc    (loadc),
        .loads    (loads),
        .out      (out),
        .n        (N),
        .v        (V),
        .z        (Z)
    );
endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: directed instructions push hand-computed
// expectations; a monitor pops and compares each time w returns high.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic [15:0] out;
    logic        N, V, Z, w;

    typedef struct {
        string       name;
        logic        chk_reg;
        logic [2:0]  rd;
        logic [15:0] rval;
        logic [15:0] out;
        logic        n, v, z;
        int          lows;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    cpu_core dut (
        .clk   (clk),
        .reset (reset),
        .s     (s),
        .load  (load),
        .in    (in),
        .out   (out),
        .N     (N),
        .V     (V),
        .Z     (Z),
        .w     (w)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] get_reg(input logic [2:0] k);
        case (k)
            3'd0: get_reg = dut.DP.REGFILE.R0;
            3'd1: get_reg = dut.DP.REGFILE.R1;
            3'd2: get_reg = dut.DP.REGFILE.R2;
            3'd3: get_reg = dut.DP.REGFILE.R3;
            3'd4: get_reg = dut.DP.REGFILE.R4;
            3'd5: get_reg = dut.DP.REGFILE.R5;
            3'd6: get_reg = dut.DP.REGFILE.R6;
            default: get_reg = dut.DP.REGFILE.R7;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expire(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // Monitor: counts w-low cycles, compares on each return to Wait.
    initial begin : monitor
        int   low_cnt;
        logic prev_w;
        exp_t e;
        low_cnt = 0;
        prev_w  = 1'b1;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (w === 1'b0) begin
                low_cnt++;
            end else if (prev_w === 1'b0) begin
                if (exp_q.size() == 0) begin
                    expire("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_cycles"}, low_cnt, e.lows);
                    check({e.name, "_out"}, out, e.out);
                    check({e.name, "_N"}, N, e.n);
                    check({e.name, "_V"}, V, e.v);
                    check({e.name, "_Z"}, Z, e.z);
                    if (e.chk_reg)
                        check($sformatf("%s_R%0d", e.name, e.rd), get_reg(e.rd), e.rval);
                end
            end
            if (w === 1'b1) low_cnt = 0;
            prev_w = w;
        end
    end

    function automatic exp_t mk(input logic [15:0] instr, input logic [2:0] rd,
                                input logic [15:0] rval, input logic [15:0] o,
                                input logic n, input logic v, input logic z, input int lows);
        exp_t e;
        e.name    = $sformatf("%04h", instr);
        e.chk_reg = 1'b1;
        e.rd      = rd;
        e.rval    = rval;
        e.out     = o;
        e.n       = n;
        e.v       = v;
        e.z       = z;
        e.lows    = lows;
        return e;
    endfunction

    task automatic issue(input logic [15:0] instr, input logic [2:0] rd, input logic [15:0] rval,
                         input logic [15:0] o, input logic n, input logic v, input logic z,
                         input int lows);
        int cnt;
        @(negedge clk);
        exp_q.push_back(mk(instr, rd, rval, o, n, v, z, lows));
        in   = instr;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s    = 1'b1;
        @(negedge clk);
        s   = 1'b0;
        cnt = 0;
        while (w !== 1'b1 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        if (w !== 1'b1) expire($sformatf("%04h_timeout", instr));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1;
        s     = 1'b0;
        load  = 1'b0;
        in    = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_w", w, 1);
        check("reset_out", out, 16'h0000);
        check("reset_NVZ", {N, V, Z}, 3'b000);
        reset  = 1'b0;
        mon_en = 1'b1;

        //     instr     Rd  value     out       N     V     Z     w-low cycles
        issue(16'hD007, 0, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
        issue(16'hD102, 1, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
        issue(16'hA148, 2, 16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0, 5);

        issue(16'hD002, 0, 16'h0002, 16'h0010, 1'b0, 1'b0, 1'b0, 2);
        issue(16'hD1FF, 1, 16'hFFFF, 16'h0010, 1'b0, 1'b0, 1'b0, 2);
        issue(16'hD208, 2, 16'h0008, 16'h0010, 1'b0, 1'b0, 1'b0, 2);
        issue(16'hC070, 3, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 4);
        issue(16'hC088, 4, 16'h0004, 16'h0004, 1'b0, 1'b0, 1'b0, 4);
        issue(16'hC0B9, 5, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4);

        issue(16'hA2C0, 6, 16'h000A, 16'h000A, 1'b0, 1'b0, 1'b0, 5);
        issue(16'hA2EC, 7, 16'h0010, 16'h0010, 1'b0, 1'b0, 1'b0, 5);
        issue(16'hA7F7, 7, 16'h0018, 16'h0018, 1'b0, 1'b0, 1'b0, 5);

        // CMP leaves C and registers untouched; R7 re-checked as unchanged.
        issue(16'hAF0E, 7, 16'h0018, 16'h0018, 1'b0, 1'b0, 1'b0, 4);
        issue(16'hA800, 0, 16'h0002, 16'h0018, 1'b0, 1'b0, 1'b1, 4);
        // R5 <- ~(R1 LSR 1) = 0x8000, then CMP R5,R3 computes 0x8000 - 1.
        issue(16'hB8B1, 5, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 4);
        issue(16'hAD03, 5, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 4);

        issue(16'hB2AC, 5, 16'h0008, 16'h0008, 1'b0, 1'b1, 1'b0, 5);
        issue(16'hB8A3, 5, 16'hFFFE, 16'hFFFE, 1'b0, 1'b1, 1'b0, 4);
        issue(16'hB8F7, 7, 16'hFFF3, 16'hFFF3, 1'b0, 1'b1, 1'b0, 4);
        issue(16'hB8C9, 6, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 4);

        // Illegal encoding: straight back to Wait, nothing changes.
        issue(16'h0000, 6, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 1);

        // ADD R6,R2,R0 aborted by reset while in GetA.
        begin : reset_mid
            @(negedge clk);
            exp_q.push_back(mk(16'hA2C0, 6, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 2));
            in   = 16'hA2C0;
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            s    = 1'b1;
            @(negedge clk);
            s = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end

        // Registers survive reset; MOV #0x80 sign-extends to 0xFF80.
        issue(16'hD080, 0, 16'hFF80, 16'h0000, 1'b0, 1'b0, 1'b0, 2);
        check("R1_after_reset", get_reg(3'd1), 16'hFFFF);

        repeat (3) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
